// File: rtl/trap_controller.sv
// Trap/sequencing controller: IDLE, MULTI_CYCLE_OP and HALT states with IRQ, exception and LSU-timeout traps.
// Define TRAP_VECTORED_IRQ_EN to vector IRQ k to offset 32+4*k; otherwise every IRQ shares offset 12.
module trap_controller #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_IRQ     = 4,
  parameter int                    CNT_WIDTH   = 4,
  parameter int                    LSU_TIMEOUT = 12,
  parameter logic [ADDR_WIDTH-1:0] MTVEC_BASE  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_valid_i,
  input  logic                  jump_inst_i,
  input  logic                  branch_inst_i,
  input  logic                  comp_result_i,
  input  logic                  ecall_inst_i,
  input  logic                  ebreak_inst_i,
  input  logic                  mret_inst_i,
  input  logic                  illegal_inst_i,
  input  logic [NUM_IRQ-1:0]    irq_i,
  input  logic [NUM_IRQ-1:0]    irq_mask_i,
  input  logic                  lsu_en_i,
  input  logic                  lsu_done_i,
  input  logic                  lsu_err_i,
  output logic [CNT_WIDTH-1:0]  cycle_counter_o,
  output logic                  deassert_rf_wen_n_o,
  output logic                  retire_o,
  output logic [1:0]            pc_mux_sel_o,
  output logic [ADDR_WIDTH-1:0] exc_pc_o,
  output logic                  save_epc_o,
  output logic                  target_valid_o,
  output logic [5:0]            cause_o,
  output logic [NUM_IRQ-1:0]    irq_ack_o,
  output logic                  halt_o
);

  typedef enum logic [1:0] {IDLE, MULTI_CYCLE_OP, HALT} state_t;

  localparam logic [1:0] PC_BRANCH_JUMP = 2'd0;
  localparam logic [1:0] PC_EXCEPTION   = 2'd1;
  localparam logic [1:0] PC_EPC         = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] OFF_ECALL       = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] OFF_ILLEGAL     = ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] OFF_LSU_FAULT   = ADDR_WIDTH'(16);
  localparam logic [ADDR_WIDTH-1:0] OFF_LSU_TIMEOUT = ADDR_WIDTH'(20);

  localparam logic [5:0] CAUSE_ILLEGAL     = 6'd2;
  localparam logic [5:0] CAUSE_LSU_FAULT   = 6'd5;
  localparam logic [5:0] CAUSE_LSU_TIMEOUT = 6'd7;
  localparam logic [5:0] CAUSE_ECALL       = 6'd11;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(LSU_TIMEOUT);

  state_t                  state;
  state_t                  cur_state;
  state_t                  next_state;
  logic [CNT_WIDTH-1:0]    cnt_next;
  logic [NUM_IRQ-1:0]      irq_pending;
  logic [4:0]              irq_idx;
  logic [ADDR_WIDTH-1:0]   irq_offset;
  logic                    trap;
  logic [ADDR_WIDTH-1:0]   trap_offset;
  logic [5:0]              trap_cause;

  // While rst is high the combinational outputs already behave as in IDLE.
  assign cur_state   = rst ? IDLE : state;
  assign irq_pending = irq_i & irq_mask_i;

  // Lowest pending index wins: scan downward so the last hit is the smallest.
  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pending[i]) irq_idx = 5'(i);
    end
  end

`ifdef TRAP_VECTORED_IRQ_EN
  assign irq_offset = ADDR_WIDTH'(32) + (ADDR_WIDTH'(irq_idx) << 2);
`else
  assign irq_offset = ADDR_WIDTH'(12);
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    next_state          = cur_state;
    retire_o            = 1'b0;
    deassert_rf_wen_n_o = 1'b0;
    pc_mux_sel_o        = PC_BRANCH_JUMP;
    target_valid_o      = 1'b0;
    save_epc_o          = 1'b0;
    exc_pc_o            = '0;
    cause_o             = '0;
    irq_ack_o           = '0;
    halt_o              = 1'b0;
    trap                = 1'b0;
    trap_offset         = '0;
    trap_cause          = '0;

    if (cur_state == HALT) begin
      halt_o = 1'b1;
    end else if (inst_valid_i) begin
      case (cur_state)
        IDLE: begin
          if (|irq_pending) begin
            trap        = 1'b1;
            trap_offset = irq_offset;
            trap_cause  = {1'b1, irq_idx};
            irq_ack_o   = NUM_IRQ'(1) << irq_idx;
          end else if (lsu_en_i && lsu_err_i) begin
            trap        = 1'b1;
            trap_offset = OFF_LSU_FAULT;
            trap_cause  = CAUSE_LSU_FAULT;
          end else if (lsu_en_i) begin
            next_state = MULTI_CYCLE_OP;
          end else if (jump_inst_i) begin
            deassert_rf_wen_n_o = 1'b1;
            next_state          = MULTI_CYCLE_OP;
          end else if (branch_inst_i) begin
            // A taken branch redirects on the following cycle; not-taken retires now.
            if (comp_result_i) next_state = MULTI_CYCLE_OP;
            else               retire_o   = 1'b1;
          end else if (mret_inst_i) begin
            pc_mux_sel_o   = PC_EPC;
            target_valid_o = 1'b1;
            retire_o       = 1'b1;
          end else if (ecall_inst_i) begin
            trap        = 1'b1;
            trap_offset = OFF_ECALL;
            trap_cause  = CAUSE_ECALL;
          end else if (illegal_inst_i) begin
            trap        = 1'b1;
            trap_offset = OFF_ILLEGAL;
            trap_cause  = CAUSE_ILLEGAL;
          end else if (ebreak_inst_i) begin
            next_state = HALT;
          end else begin
            retire_o            = 1'b1;
            deassert_rf_wen_n_o = 1'b1;
          end
        end

        MULTI_CYCLE_OP: begin
          if (lsu_en_i && !lsu_done_i) begin
            if (cycle_counter_o == TIMEOUT_CNT) begin
              trap        = 1'b1;
              trap_offset = OFF_LSU_TIMEOUT;
              trap_cause  = CAUSE_LSU_TIMEOUT;
              next_state  = IDLE;
            end
          end else if (lsu_done_i || jump_inst_i || branch_inst_i) begin
            retire_o            = 1'b1;
            target_valid_o      = jump_inst_i || branch_inst_i;
            deassert_rf_wen_n_o = !branch_inst_i;
            next_state          = IDLE;
          end
        end

        default: ;
      endcase
    end

    if (trap) begin
      pc_mux_sel_o        = PC_EXCEPTION;
      target_valid_o      = 1'b1;
      save_epc_o          = 1'b1;
      retire_o            = 1'b0;
      deassert_rf_wen_n_o = 1'b0;
      exc_pc_o            = MTVEC_BASE + trap_offset;
      cause_o             = trap_cause;
    end
  end

  // Counter restarts whenever the FSM heads back to IDLE, otherwise saturates.
  always_comb begin
    if (next_state == IDLE)     cnt_next = '0;
    else if (&cycle_counter_o)  cnt_next = cycle_counter_o;
    else                        cnt_next = cycle_counter_o + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state           <= IDLE;
      cycle_counter_o <= '0;
    end else if (inst_valid_i) begin
      state           <= next_state;
      cycle_counter_o <= cnt_next;
    end
  end

endmodule
